key_expansion: RTL and testbench

//  AES key schedule that directly feeds the cipher datapath. It emits one 128-bit round key per cycle:

---
 rtl/key_expansion.sv | 168 ++++++++++++++++
 tb/tb_key_expansion.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
`default_nettype none
// ---------------------------------------------------------------------------------------------
// key_expansion : AES-128/192/256 key schedule streaming one 128-bit round key per cycle. Rev 1.0
// ---------------------------------------------------------------------------------------------
module key_expansion (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   keySize,
  input  logic [255:0] key,
  output logic [127:0] roundKey,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] hist [8];   // hist[k] holds the word issued k+1 positions before the next one
  logic [31:0] ext  [4];   // key words w4..w7, issued directly in round 1
  logic [3:0]  nk, nr, pos, pos_next;
  logic [7:0]  rcon;
  logic [3:0]  lane_key, lane_sub, lane_rot;
  logic [31:0] lane [4];
  logic [31:0] sub_in, sub_out;
  logic        rcon_step;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (start) state_next = RUN;
               else if (round + 4'd1 == nr) state_next = FIN;
      FIN:     if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == FIN);

  // Per-lane classification: lane j produces word index base+j, whose position mod Nk is pos+j.
  always_comb begin : lane_flags
    logic [3:0] p;
    p        = '0;
    lane_key = '0;
    lane_sub = '0;
    lane_rot = '0;
    for (int j = 0; j < 4; j++) begin
      p = pos + 4'(j);
      if (p >= nk) p = p - nk;
      lane_key[j] = (round == 4'd0) && ((4'd4 + 4'(j)) < nk);
      lane_rot[j] = (p == 4'd0);
      lane_sub[j] = !lane_key[j] && (lane_rot[j] || (nk == 4'd8 && p == 4'd4));
    end
  end

  assign rcon_step = |(lane_sub & lane_rot);

  // Lanes ahead of the single SubWord lane use only XOR chaining, so the S-box input
  // is taken from that S-box-free prefix chain.
  always_comb begin : sub_select
    logic [31:0] prev;
    prev   = hist[0];
    sub_in = hist[0];
    for (int j = 0; j < 4; j++) begin
      if (lane_sub[j]) sub_in = prev;
      prev = lane_key[j] ? ext[j] : (hist[3'(nk - 4'd1 - 4'(j))] ^ prev);
    end
  end

  assign sub_out = sub_word(sub_in);

  always_comb begin : lane_gen
    logic [31:0] prev;
    logic [31:0] t;
    prev = hist[0];
    t    = '0;
    for (int j = 0; j < 4; j++) begin
      t = prev;
      if (lane_sub[j])
        t = lane_rot[j] ? ({sub_out[23:0], sub_out[31:24]} ^ {rcon, 24'h0}) : sub_out;
      lane[j] = lane_key[j] ? ext[j] : (hist[3'(nk - 4'd1 - 4'(j))] ^ t);
      prev    = lane[j];
    end
  end

  always_comb begin
    pos_next = pos + 4'd4;
    if (pos_next >= nk) pos_next = pos_next - nk;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      roundKey <= '0;
      round    <= '0;
      rcon     <= 8'h01;
      nk       <= 4'd4;
      nr       <= 4'd10;
      pos      <= '0;
      for (int k = 0; k < 8; k++) hist[k] <= '0;
      for (int k = 0; k < 4; k++) ext[k]  <= '0;
    end else if (start) begin
      roundKey <= key[255:128];
      round    <= '0;
      rcon     <= 8'h01;
      case (keySize)
        2'b01:   begin nk <= 4'd6; nr <= 4'd12; pos <= 4'd4; end
        2'b10:   begin nk <= 4'd8; nr <= 4'd14; pos <= 4'd4; end
        default: begin nk <= 4'd4; nr <= 4'd10; pos <= 4'd0; end
      endcase
      hist[0] <= key[159:128];
      hist[1] <= key[191:160];
      hist[2] <= key[223:192];
      hist[3] <= key[255:224];
      for (int k = 4; k < 8; k++) hist[k] <= '0;
      ext[0] <= key[127:96];
      ext[1] <= key[95:64];
      ext[2] <= key[63:32];
      ext[3] <= key[31:0];
    end else if (state == RUN) begin
      roundKey <= {lane[0], lane[1], lane[2], lane[3]};
      round    <= round + 4'd1;
      pos      <= pos_next;
      hist[0]  <= lane[3];
      hist[1]  <= lane[2];
      hist[2]  <= lane[1];
      hist[3]  <= lane[0];
      for (int k = 4; k < 8; k++) hist[k] <= hist[k-4];
      if (rcon_step) rcon <= xtime(rcon);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_expansion.sv
`default_nettype none
// tb_key_expansion : FIPS-197 vector table, restart/reset sequences, cipher round-trip and
// randomized keys checked against a textbook key-expansion model.
module tb_key_expansion;

  localparam logic [255:0] A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   keySize = 2'b00;
  logic [255:0] key = '0;
  logic [127:0] roundKey;
  logic [3:0]   round;
  logic         busy, done;

  key_expansion dut (
    .clk(clk), .reset(reset), .start(start), .keySize(keySize), .key(key),
    .roundKey(roundKey), .round(round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [7:0]   sbox_m [256];
  logic [31:0]  mw [60];
  int           m_nr;
  logic [127:0] cap_rk [15];
  logic [7:0]   rcon_tab [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef struct {
    logic [1:0]   ks;
    logic [255:0] k;
    int           rnd;
    logic [127:0] rk;
    logic         dn;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  task automatic expand(input logic [1:0] ks, input logic [255:0] k);
    int nk;
    logic [31:0] tmp;
    nk   = (ks == 2'b01) ? 6 : (ks == 2'b10) ? 8 : 4;
    m_nr = nk + 6;
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(m_nr+1); i++) begin
      tmp = mw[i-1];
      if (i % nk == 0)               tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[i/nk], 24'h0};
      else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
      mw[i] = mw[i-nk] ^ tmp;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v = {v[223:0], 32'($urandom)};
    return v;
  endfunction

  // AES-128 encryption using the round keys captured from the DUT.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] ct;
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ cap_rk[0][127-8*n -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox_m[s[n]];
      for (int n = 0; n < 16; n++) s[n] = t[(n%4) + 4*(((n/4) + (n%4)) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int n = 0; n < 16; n++) s[n] ^= cap_rk[r][127-8*n -: 8];
    end
    ct = '0;
    for (int n = 0; n < 16; n++) ct[127-8*n -: 8] = s[n];
    return ct;
  endfunction

  // Called at a negedge; key/keySize are scrambled after the sampling edge.
  task automatic pulse_start(input logic [1:0] ks, input logic [255:0] k);
    start   = 1'b1;
    keySize = ks;
    key     = k;
    @(posedge clk);
    #1;
    start   = 1'b0;
    keySize = 2'($urandom);
    key     = rand256();
  endtask

  task automatic run_full(input logic [1:0] ks, input logic [255:0] k, input string tag);
    logic [127:0] last;
    expand(ks, k);
    pulse_start(ks, k);
    for (int r = 0; r <= m_nr; r++) begin
      @(negedge clk);
      cap_rk[r] = roundKey;
      check({tag, " roundKey"}, roundKey, model_rk(r));
      check({tag, " round"}, 128'(round), 128'(r));
      check({tag, " busy,done"}, 128'({busy, done}), 128'({r < m_nr, r == m_nr}));
    end
    last = model_rk(m_nr);
    repeat (2) @(negedge clk);
    check({tag, " hold key"}, roundKey, last);
    check({tag, " hold round,busy,done"}, 128'({round, busy, done}), 128'({4'(m_nr), 1'b0, 1'b1}));
  endtask

  initial begin
    build_sbox();

    vecs[0] = '{2'b00, A1, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0};
    vecs[1] = '{2'b00, A1, 1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
    vecs[2] = '{2'b00, A1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
    vecs[3] = '{2'b11, A1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
    vecs[4] = '{2'b01, A2, 0,  128'h8e73b0f7da0e6452c810f32b809079e5, 1'b0};
    vecs[5] = '{2'b01, A2, 1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, 1'b0};
    vecs[6] = '{2'b01, A2, 12, 128'he98ba06f448c773c8ecc720401002202, 1'b1};
    vecs[7] = '{2'b10, A3, 0,  128'h603deb1015ca71be2b73aef0857d7781, 1'b0};
    vecs[8] = '{2'b10, A3, 1,  128'h1f352c073b6108d72d9810a30914dff4, 1'b0};
    vecs[9] = '{2'b10, A3, 14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1};

    // Reset state, then idle with no start.
    @(negedge clk);
    check("reset outputs", {roundKey[123:0], round}, 128'h0);
    check("reset busy,done", 128'({busy, done}), 128'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle busy,done,round", 128'({busy, done, round}), 128'h0);

    // FIPS-197 vector table.
    for (int v = 0; v < 10; v++) begin
      pulse_start(vecs[v].ks, vecs[v].k);
      repeat (vecs[v].rnd + 1) @(negedge clk);
      check($sformatf("vec%0d roundKey", v), roundKey, vecs[v].rk);
      check($sformatf("vec%0d round", v), 128'(round), 128'(vecs[v].rnd));
      check($sformatf("vec%0d done", v), 128'(done), 128'(vecs[v].dn));
    end

    // Full A.1 schedule and the cipher run that consumes it.
    run_full(2'b00, A1, "A1");
    check("A1 cipher", aes_enc(128'h3243f6a8885a308d313198a2e0370734),
          128'h3925841d02dc09fbdc118597196a0b32);
    run_full(2'b01, A2, "A2");
    run_full(2'b10, A3, "A3");

    // Restart from round 5 of a 256-bit schedule.
    expand(2'b10, A3);
    pulse_start(2'b10, A3);
    repeat (6) @(negedge clk);
    check("pre-restart roundKey", roundKey, model_rk(5));
    run_full(2'b00, A1, "restart A1");

    // Asynchronous reset at round 3.
    pulse_start(2'b00, A1);
    repeat (4) @(negedge clk);
    check("pre-reset round", 128'(round), 128'd3);
    reset = 1'b0;
    #1;
    check("async reset roundKey", roundKey, 128'h0);
    check("async reset round,busy,done", 128'({round, busy, done}), 128'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset idle", 128'({round, busy, done}), 128'h0);
    run_full(2'b00, A1, "post-reset A1");

    // Randomized keys and key sizes, including the 2'b11 encoding.
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_full(2'($urandom_range(0, 3)), rand256(), $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
